// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared button event definitions
// Purpose: button count, event width and event field positions shared by the
//          button controller and the MMIO decoder that reads its events.
// Ports:   none (package)
package btn_pkg;

   localparam int N_BTN         = 4;
   localparam int EVT_W         = 3;
   localparam int EVT_PRESS_BIT = 2;
   localparam int EVT_IDX_MSB   = 1;
   localparam int EVT_IDX_LSB   = 0;

   // Packs one event word: press flag above the button index.
   function automatic logic [EVT_W-1:0] make_evt(input logic press, input logic [1:0] idx);
      logic [EVT_W-1:0] evt;
      evt                          = '0;
      evt[EVT_PRESS_BIT]           = press;
      evt[EVT_IDX_MSB:EVT_IDX_LSB] = idx;
      return evt;
   endfunction

endpackage

// File: rtl/btn_evt_fifo.sv
// rtl/btn_evt_fifo.sv - synchronous event FIFO
// Purpose: holds queued button events between the arbiter and the consumer.
// Ports:   CLK, nrst (async active-low), push/din write side, pop/dout read
//          side, full/empty status. Push while full and pop while empty are
//          ignored; simultaneous push and pop leave the count unchanged.
module btn_evt_fifo
   import btn_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic             CLK,
   input  logic             nrst,
   input  logic             push,
   input  logic [EVT_W-1:0] din,
   input  logic             pop,
   output logic [EVT_W-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

   logic [EVT_W-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign full      = (r_count == DEPTH_C);
   assign empty     = (r_count == '0);
   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;
   assign dout      = r_mem[r_rd_ptr];

   // Depth is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge CLK or negedge nrst) begin
      if (!nrst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
         else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
      end
   end

endmodule

// File: rtl/btn_event_ctrl.sv
// rtl/btn_event_ctrl.sv - debounced button press/release event queue
// Purpose: synchronizes and debounces four raw buttons, arbitrates accepted
//          level changes round-robin into an event FIFO, flags lost events.
// Ports:   CLK, nrst (async active-low); btn raw inputs; btn_state debounced
//          levels; evt_valid/evt_code/evt_ready consumer handshake
//          (code = {press, index}); overflow sticky loss flag, clr_ovf clear.
module btn_event_ctrl
   import btn_pkg::*;
#(
   parameter int DB_BITS    = 21,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             CLK,
   input  logic             nrst,
   input  logic [N_BTN-1:0] btn,
   output logic [N_BTN-1:0] btn_state,
   output logic             evt_valid,
   output logic [EVT_W-1:0] evt_code,
   input  logic             evt_ready,
   output logic             overflow,
   input  logic             clr_ovf
);

   // Acceptance happens on the DB_MAX-th consecutive mismatch cycle.
   localparam logic [DB_BITS-1:0] DB_MAX_M1 = {1'b0, {(DB_BITS-1){1'b1}}};

   logic [N_BTN-1:0] r_sync1;
   logic [N_BTN-1:0] r_sync2;
   logic [1:0]       r_rr;
   logic             r_ovf;

   logic [N_BTN-1:0] w_state;
   logic [N_BTN-1:0] w_pending;
   logic [N_BTN-1:0] w_ptype;
   logic [N_BTN-1:0] w_accept;
   logic [N_BTN-1:0] w_grant_oh;
   logic [1:0]       w_grant_idx;
   logic [1:0]       w_cand;
   logic             w_found;
   logic             w_push;
   logic             w_full;
   logic             w_empty;
   logic             w_lost;
   logic [EVT_W-1:0] w_din;

   always_ff @(posedge CLK or negedge nrst) begin
      if (!nrst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= btn;
         r_sync2 <= r_sync1;
      end
   end

   for (genvar gi = 0; gi < N_BTN; gi++) begin : g_db
      logic [DB_BITS-1:0] r_cnt;
      logic               r_state;
      logic               r_pending;
      logic               r_ptype;

      assign w_accept[gi]  = (r_sync2[gi] != r_state) && (r_cnt == DB_MAX_M1);
      assign w_state[gi]   = r_state;
      assign w_pending[gi] = r_pending;
      assign w_ptype[gi]   = r_ptype;

      always_ff @(posedge CLK or negedge nrst) begin
         if (!nrst) begin
            r_cnt     <= '0;
            r_state   <= 1'b0;
            r_pending <= 1'b0;
            r_ptype   <= 1'b0;
         end else begin
            if (r_sync2[gi] == r_state) begin
               r_cnt <= '0;
            end else if (r_cnt == DB_MAX_M1) begin
               r_cnt   <= '0;
               r_state <= r_sync2[gi];
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
            // A fresh acceptance outranks the grant of the previous event;
            // when both coincide the old event is pushed and the new one stays.
            if (w_accept[gi]) begin
               r_pending <= 1'b1;
               r_ptype   <= r_sync2[gi];
            end else if (w_grant_oh[gi]) begin
               r_pending <= 1'b0;
            end
         end
      end
   end

   // Round-robin search starting at r_rr; full comes from the registered count.
   always_comb begin
      w_grant_oh  = '0;
      w_grant_idx = r_rr;
      w_cand      = r_rr;
      w_found     = 1'b0;
      for (int k = 0; k < N_BTN; k++) begin
         w_cand = r_rr + 2'(k);
         if (!w_found && w_pending[w_cand]) begin
            w_found     = 1'b1;
            w_grant_idx = w_cand;
         end
      end
      if (w_found && !w_full) w_grant_oh[w_grant_idx] = 1'b1;
   end

   assign w_push = w_found && !w_full;
   assign w_din  = make_evt(w_ptype[w_grant_idx], w_grant_idx);

   // An event is lost only if its pending slot is overwritten without being pushed.
   assign w_lost = |(w_accept & w_pending & ~w_grant_oh);

   always_ff @(posedge CLK or negedge nrst) begin
      if (!nrst) begin
         r_rr  <= '0;
         r_ovf <= 1'b0;
      end else begin
         if (w_push) r_rr <= w_grant_idx + 1'b1;
         if (w_lost)       r_ovf <= 1'b1;
         else if (clr_ovf) r_ovf <= 1'b0;
      end
   end

   btn_evt_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK   (CLK),
      .nrst  (nrst),
      .push  (w_push),
      .din   (w_din),
      .pop   (evt_valid && evt_ready),
      .dout  (evt_code),
      .full  (w_full),
      .empty (w_empty)
   );

   assign evt_valid = !w_empty;
   assign btn_state = w_state;
   assign overflow  = r_ovf;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// tb/tb_btn_event_ctrl.sv - directed self-checking bench for btn_event_ctrl
module tb_btn_event_ctrl;

   logic       CLK;
   logic       nrst;
   logic [3:0] btn;
   logic [3:0] btn_state;
   logic       evt_valid;
   logic [2:0] evt_code;
   logic       evt_ready;
   logic       overflow;
   logic       clr_ovf;

   int n_checks;
   int n_errors;

   btn_event_ctrl #(
      .DB_BITS    (4),
      .FIFO_DEPTH (4)
   ) dut (
      .CLK       (CLK),
      .nrst      (nrst),
      .btn       (btn),
      .btn_state (btn_state),
      .evt_valid (evt_valid),
      .evt_code  (evt_code),
      .evt_ready (evt_ready),
      .overflow  (overflow),
      .clr_ovf   (clr_ovf)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL timeout: run did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Leaves the bench 1 ns after a rising edge.
   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // Asserts reset mid-cycle, checks outputs clear at once, releases on the falling edge.
   task automatic do_reset(input string tag);
      @(posedge CLK);
      #3 nrst = 1'b0;
      #1;
      chk({tag, "_state"}, 32'(btn_state), 32'h0);
      chk({tag, "_valid"}, 32'(evt_valid), 32'h0);
      chk({tag, "_ovf"},   32'(overflow),  32'h0);
      @(negedge CLK);
      nrst = 1'b1;
      tick(1);
   endtask

   logic [2:0] exp_seq [5];

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      nrst      = 1'b1;
      btn       = 4'h0;
      evt_ready = 1'b0;
      clr_ovf   = 1'b0;

      // 1: reset, then idle
      do_reset("t1_rst");
      tick(50);
      chk("t1_idle_state", 32'(btn_state), 32'h0);
      chk("t1_idle_valid", 32'(evt_valid), 32'h0);

      // 2: single press latency and pop
      btn = 4'b0001;
      tick(9);
      chk("t2_state_k9", 32'(btn_state), 32'h0);
      tick(1);
      chk("t2_state_k10", 32'(btn_state), 32'h1);
      chk("t2_valid_k10", 32'(evt_valid), 32'h0);
      tick(1);
      chk("t2_valid_k11", 32'(evt_valid), 32'h1);
      chk("t2_code",      32'(evt_code),  32'h4);
      evt_ready = 1'b1;
      tick(1);
      evt_ready = 1'b0;
      chk("t2_popped", 32'(evt_valid), 32'h0);

      // 3: short glitch is ignored and leaves the counter at zero
      btn = 4'b0011;
      tick(5);
      btn = 4'b0001;
      tick(20);
      chk("t3_state", 32'(btn_state), 32'h1);
      chk("t3_valid", 32'(evt_valid), 32'h0);
      btn = 4'b0011;
      tick(9);
      chk("t3_full_k9",  32'(btn_state), 32'h1);
      tick(1);
      chk("t3_full_k10", 32'(btn_state), 32'h3);
      tick(1);
      chk("t3_code", 32'(evt_code), 32'h5);
      btn = 4'h0;

      // 4: simultaneous presses then releases, round-robin from 0
      do_reset("t4_rst");
      evt_ready = 1'b1;
      btn = 4'hF;
      for (int c = 0; c < 30 && !evt_valid; c++) tick(1);
      chk("t4_press_seen", 32'(evt_valid), 32'h1);
      for (int j = 0; j < 4; j++) begin
         chk("t4_press_valid", 32'(evt_valid), 32'h1);
         chk("t4_press_code",  32'(evt_code),  32'(4 + j));
         tick(1);
      end
      chk("t4_press_drained", 32'(evt_valid), 32'h0);
      chk("t4_state_f", 32'(btn_state), 32'hF);
      btn = 4'h0;
      for (int c = 0; c < 30 && !evt_valid; c++) tick(1);
      chk("t4_rel_seen", 32'(evt_valid), 32'h1);
      for (int j = 0; j < 4; j++) begin
         chk("t4_rel_valid", 32'(evt_valid), 32'h1);
         chk("t4_rel_code",  32'(evt_code),  32'(j));
         tick(1);
      end
      chk("t4_rel_drained", 32'(evt_valid), 32'h0);
      evt_ready = 1'b0;

      // 5: six changes on button 2 with no consumer -> overflow
      for (int j = 0; j < 5; j++) begin
         btn = (j % 2 == 0) ? 4'b0100 : 4'b0000;
         tick(12);
      end
      chk("t5_ovf_before", 32'(overflow), 32'h0);
      btn = 4'b0000;
      tick(12);
      chk("t5_ovf_after", 32'(overflow), 32'h1);
      exp_seq[0] = 3'b110;
      exp_seq[1] = 3'b010;
      exp_seq[2] = 3'b110;
      exp_seq[3] = 3'b010;
      exp_seq[4] = 3'b010;
      evt_ready = 1'b1;
      for (int j = 0; j < 5; j++) begin
         chk("t5_drain_valid", 32'(evt_valid), 32'h1);
         chk("t5_drain_code",  32'(evt_code),  32'(exp_seq[j]));
         tick(1);
      end
      chk("t5_drain_empty", 32'(evt_valid), 32'h0);
      evt_ready = 1'b0;
      chk("t5_ovf_sticky", 32'(overflow), 32'h1);
      clr_ovf = 1'b1;
      tick(1);
      clr_ovf = 1'b0;
      chk("t5_ovf_clr", 32'(overflow), 32'h0);

      // 6: reset mid-debounce restarts the full latency
      btn = 4'b1000;
      tick(7);
      chk("t6_state_pre", 32'(btn_state), 32'h0);
      #2 nrst = 1'b0;
      #1;
      chk("t6_rst_state", 32'(btn_state), 32'h0);
      chk("t6_rst_valid", 32'(evt_valid), 32'h0);
      chk("t6_rst_ovf",   32'(overflow),  32'h0);
      @(negedge CLK);
      nrst = 1'b1;
      tick(9);
      chk("t6_state_r9", 32'(btn_state), 32'h0);
      chk("t6_valid_r9", 32'(evt_valid), 32'h0);
      tick(1);
      chk("t6_state_r10", 32'(btn_state), 32'h8);
      tick(1);
      chk("t6_valid_r11", 32'(evt_valid), 32'h1);
      chk("t6_code",      32'(evt_code),  32'h7);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
